fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter p_WORD_LEN, default 8, data bits per frame.
REQ-002 SHALL have parameter p_CLKS_PER_BIT, default 16, i_clk cycles per serial bit; legal range is at least 2.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_deq_data  input  p_WORD_LEN  word at the FIFO head; valid while i_deq_rdy=1.
REQ-006 i_deq_rdy  input  1  FIFO non-empty.
REQ-007 o_deq_en  output  1  dequeue strobe; each high cycle consumes exactly one word.
REQ-008 o_tx  output  1  serial line; idles high.
REQ-009 o_busy  output  1  high from the START state through the last STOP cycle.
REQ-010 o_done  output  1  one-cycle pulse in the final cycle of each STOP bit.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-026.
REQ-012 o_deq_en SHALL be combinational: high only when (state=IDLE, or the last STOP cycle) and i_deq_rdy=1 and i_reset=0.
REQ-013 On an edge with o_deq_en=1, i_deq_data SHALL be latched into the shift register and the FSM SHALL enter START.
REQ-014 o_tx SHALL be registered: IDLE=1, START=0, DATA=current LSB, PARITY=parity bit, STOP=1.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL last exactly p_CLKS_PER_BIT cycles, timed by a counter running 0..p_CLKS_PER_BIT-1.
REQ-016 DATA SHALL send p_WORD_LEN bits LSB first; a bit index from 0 to p_WORD_LEN-1 SHALL select DATA->PARITY/STOP on the last count.
REQ-017 Frame length SHALL be (2+p_WORD_LEN+P)*p_CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
REQ-018 Back-to-back: if i_deq_rdy=1 in the last STOP cycle, the next START SHALL begin on the following cycle with no idle gap.
REQ-019 If i_deq_rdy=0 in the last STOP cycle, the FSM SHALL go to IDLE and o_tx SHALL stay 1.
REQ-020 i_deq_data and i_deq_rdy SHALL be ignored outside IDLE and the last STOP cycle; a word arriving mid-frame waits.
REQ-021 o_deq_en SHALL never be high for two cycles within one frame; exactly one dequeue per frame.

Reset
REQ-022 While i_reset=1: state=IDLE, counter=0, bit index=0, shift register=0, o_tx=1, o_busy=0, o_done=0, o_deq_en=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame: o_tx=1 on the next edge, and the partial word is discarded and not re-dequeued.
REQ-024 In the first cycle after reset release, i_deq_rdy=1 SHALL cause o_deq_en=1.

Configuration
REQ-025 Macro FIFO_UART_TX_PARITY_EN SHALL select parity support at compile time.
REQ-026 With the macro defined: a PARITY state SHALL follow DATA and send even parity, the XOR of the latched word, for p_CLKS_PER_BIT cycles.
REQ-027 Without the macro: there SHALL be no PARITY state or logic, and DATA SHALL go directly to STOP.

Verification
REQ-028 p_CLKS_PER_BIT=4, no parity, i_deq_rdy pulses with data 0xA5 -> one o_deq_en cycle; o_tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; 40 cycles total; o_done pulses at cycle 40.
REQ-029 FIFO_UART_TX_PARITY_EN defined, p_CLKS_PER_BIT=4, data 0x07 -> parity bit 1 for 4 cycles before STOP; frame is 44 cycles.
REQ-030 i_deq_rdy held 1 with three queued words 0x01, 0x02, 0x03 -> three o_deq_en pulses 40 cycles apart; o_tx has no high gap between a STOP and the next START.
REQ-031 i_deq_rdy held 0 for 100 cycles -> o_tx=1, o_busy=0, o_deq_en=0 throughout.
REQ-032 i_reset asserted at cycle 15 of a frame -> o_tx=1 and o_busy=0 next cycle; after release with i_deq_rdy=1, the next word starts a fresh frame.
REQ-033 i_deq_rdy toggling during DATA -> o_deq_en stays 0 until the last STOP cycle.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: serialises words from a FIFO head (START, LSB-first DATA, optional even PARITY, STOP).
// Latency: START begins the cycle after the dequeue edge; one frame is (2+p_WORD_LEN+P)*p_CLKS_PER_BIT cycles.
// Backpressure: words are taken only when idle or in the last STOP cycle; i_deq_rdy is ignored mid-frame.
// Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx #(
  parameter int p_WORD_LEN     = 8,
  parameter int p_CLKS_PER_BIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [p_WORD_LEN-1:0] i_deq_data,
  input  logic                  i_deq_rdy,
  output logic                  o_deq_en,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = (p_CLKS_PER_BIT > 1) ? $clog2(p_CLKS_PER_BIT) : 1;
  localparam int IDX_W = (p_WORD_LEN > 1) ? $clog2(p_WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_WORD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [p_WORD_LEN-1:0]   shreg_q, shreg_d;
  logic                    bit_end;
  logic                    tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                    par_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    tx_d     = 1'b1;
    bit_end  = (cnt_q == CNT_LAST);
    o_busy   = (state_q != IDLE);
    o_done   = (state_q == STOP) && bit_end;
    o_deq_en = ((state_q == IDLE) || o_done) && i_deq_rdy && !i_reset;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A dequeue overrides the STOP->IDLE exit so frames run back to back.
    if (o_deq_en) begin
      state_d = START;
      shreg_d = i_deq_data;
      cnt_d   = '0;
      idx_d   = '0;
    end

    case (state_d)
      START: tx_d = 1'b0;
      DATA:  tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      o_tx    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      o_tx    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      if (o_deq_en) par_q <= ^i_deq_data;
`endif
    end
  end

endmodule
